// File: rtl/coefficient_sequencer.sv
// Coefficient load sequencer for a FIR datapath.
// Issues one-cycle load strobes for NUM_COEFF coefficients in ascending or
// descending order, waiting for modwait to drop between loads. An optional
// settle gap follows each strobe. Reload requests that arrive mid-sequence
// are queued, and abort terminates the sequence. Busy and done status are
// also reported.
module coefficient_sequencer #(
    parameter int NUM_COEFF  = 4,
    parameter int SETTLE_CYC = 0,
    localparam int IDX_W     = (NUM_COEFF > 1) ? $clog2(NUM_COEFF) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             new_coefficient_set,
    input  logic             modwait,
    input  logic             reverse,
    input  logic             abort,
    output logic             load_coeff,
    output logic [IDX_W-1:0] coefficient_num,
    output logic             busy,
    output logic             load_done
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        SETTLE = 3'd2,
        WAIT   = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_COEFF - 1);
    localparam logic [3:0]       SETTLE_LOAD = (SETTLE_CYC > 0) ? 4'(SETTLE_CYC - 1) : 4'd0;

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_next;
    logic             pending;
    logic             pending_next;
    logic             dir;
    logic             dir_next;
    logic [3:0]       settle_cnt;
    logic [3:0]       settle_cnt_next;
    logic             at_last;

    // The final index depends on the direction latched at sequence start.
    assign at_last = dir ? (idx == '0) : (idx == LAST_IDX);

    // State and sequence registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= '0;
            pending    <= 1'b0;
            dir        <= 1'b0;
            settle_cnt <= '0;
        end else begin
            state      <= state_next;
            idx        <= idx_next;
            pending    <= pending_next;
            dir        <= dir_next;
            settle_cnt <= settle_cnt_next;
        end
    end

    // Next-state logic. The last-index check is made before any index step
    // so the index never wraps. Abort overrides every other transition.
    always_comb begin
        state_next      = state;
        idx_next        = idx;
        pending_next    = pending;
        dir_next        = dir;
        settle_cnt_next = settle_cnt;

        if (state != IDLE && new_coefficient_set) begin
            pending_next = 1'b1;
        end

        case (state)
            IDLE: begin
                if ((new_coefficient_set || pending) && !modwait) begin
                    state_next   = LOAD;
                    idx_next     = reverse ? LAST_IDX : '0;
                    dir_next     = reverse;
                    pending_next = 1'b0;
                end
            end
            LOAD: begin
                if (at_last) begin
                    state_next = DONE;
                end else if (SETTLE_CYC > 0) begin
                    state_next      = SETTLE;
                    settle_cnt_next = SETTLE_LOAD;
                end else begin
                    state_next = WAIT;
                end
            end
            SETTLE: begin
                if (settle_cnt == '0) begin
                    state_next = WAIT;
                end else begin
                    settle_cnt_next = settle_cnt - 4'd1;
                end
            end
            WAIT: begin
                if (!modwait) begin
                    idx_next   = dir ? (idx - IDX_W'(1)) : (idx + IDX_W'(1));
                    state_next = LOAD;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (abort && state != IDLE) begin
            state_next   = IDLE;
            pending_next = 1'b0;
        end
    end

    // Moore outputs decoded from the registered state only.
    always_comb begin
        load_coeff      = (state == LOAD);
        busy            = (state != IDLE);
        load_done       = (state == DONE);
        coefficient_num = (state == IDLE) ? '0 : idx;
    end

endmodule

// File: tb/tb_coefficient_sequencer.sv
// Bench for coefficient_sequencer: three instances (4/0, 8/2, 1/0) share the
// same inputs and are checked each cycle against a positional model.
module tb_coefficient_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b1;
    logic new_set = 1'b0;
    logic modwait = 1'b0;
    logic reverse = 1'b0;
    logic abort = 1'b0;

    logic       lc4, bz4, dn4;
    logic [1:0] num4;
    logic       lc8, bz8, dn8;
    logic [2:0] num8;
    logic       lc1, bz1, dn1;
    logic [0:0] num1;

    coefficient_sequencer #(.NUM_COEFF(4), .SETTLE_CYC(0)) dut4 (
        .clk(clk), .reset(reset), .new_coefficient_set(new_set), .modwait(modwait),
        .reverse(reverse), .abort(abort), .load_coeff(lc4), .coefficient_num(num4),
        .busy(bz4), .load_done(dn4)
    );
    coefficient_sequencer #(.NUM_COEFF(8), .SETTLE_CYC(2)) dut8 (
        .clk(clk), .reset(reset), .new_coefficient_set(new_set), .modwait(modwait),
        .reverse(reverse), .abort(abort), .load_coeff(lc8), .coefficient_num(num8),
        .busy(bz8), .load_done(dn8)
    );
    coefficient_sequencer #(.NUM_COEFF(1), .SETTLE_CYC(0)) dut1 (
        .clk(clk), .reset(reset), .new_coefficient_set(new_set), .modwait(modwait),
        .reverse(reverse), .abort(abort), .load_coeff(lc1), .coefficient_num(num1),
        .busy(bz1), .load_done(dn1)
    );

    logic       a_lc[3], a_bz[3], a_dn[3];
    logic [7:0] a_num[3];
    assign a_lc[0] = lc4; assign a_bz[0] = bz4; assign a_dn[0] = dn4; assign a_num[0] = 8'(num4);
    assign a_lc[1] = lc8; assign a_bz[1] = bz8; assign a_dn[1] = dn8; assign a_num[1] = 8'(num8);
    assign a_lc[2] = lc1; assign a_bz[2] = bz1; assign a_dn[2] = dn1; assign a_num[2] = 8'(num1);

    localparam int MN[3] = '{4, 8, 1};
    localparam int MS[3] = '{0, 2, 0};

    int n_cmp = 0;
    int n_err = 0;
    bit chk_on = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Positional model: per instance, whether a sequence is active, which
    // ordinal load it is on, and whether the current cycle is a strobe, a
    // settle gap cycle, a wait for modwait, or the done pulse.
    bit m_act[3], m_strb[3], m_done[3], m_pend[3], m_dir[3];
    int m_pos[3], m_gap[3];

    function automatic void step(int k);
        if (reset) begin
            m_act[k] = 0; m_strb[k] = 0; m_done[k] = 0; m_pend[k] = 0;
            m_dir[k] = 0; m_pos[k] = 0; m_gap[k] = 0;
        end else if (!m_act[k]) begin
            if ((new_set || m_pend[k]) && !modwait) begin
                m_act[k] = 1; m_pos[k] = 0; m_strb[k] = 1; m_gap[k] = 0;
                m_dir[k] = reverse; m_pend[k] = 0;
            end
        end else if (abort) begin
            m_act[k] = 0; m_strb[k] = 0; m_done[k] = 0; m_pend[k] = 0;
        end else begin
            if (new_set) m_pend[k] = 1;
            if (m_strb[k]) begin
                m_strb[k] = 0;
                if (m_pos[k] == MN[k] - 1) m_done[k] = 1;
                else m_gap[k] = MS[k];
            end else if (m_done[k]) begin
                m_done[k] = 0;
                m_act[k] = 0;
            end else if (m_gap[k] > 0) begin
                m_gap[k]--;
            end else if (!modwait) begin
                m_pos[k]++;
                m_strb[k] = 1;
            end
        end
    endfunction

    function automatic int e_num(int k);
        if (!m_act[k]) return 0;
        return m_dir[k] ? (MN[k] - 1 - m_pos[k]) : m_pos[k];
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) step(k);
    end

    // Every-cycle comparison of all instances against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("load_coeff[%0d]", k), int'(a_lc[k]), int'(m_strb[k]));
                chk($sformatf("coefficient_num[%0d]", k), int'(a_num[k]), e_num(k));
                chk($sformatf("busy[%0d]", k), int'(a_bz[k]), int'(m_act[k]));
                chk($sformatf("load_done[%0d]", k), int'(a_dn[k]), int'(m_done[k]));
            end
        end
    end

    // Event log of the 4-coefficient instance.
    int cyc = 0;
    int q_snum[$], q_scyc[$], q_dcyc[$];
    always @(negedge clk) begin
        cyc++;
        if (lc4 === 1'b1) begin q_snum.push_back(int'(num4)); q_scyc.push_back(cyc); end
        if (dn4 === 1'b1) q_dcyc.push_back(cyc);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_log();
        q_snum.delete(); q_scyc.delete(); q_dcyc.delete();
    endtask

    task automatic wait_strobe4(input int want);
        int t;
        t = 0;
        while (!(lc4 === 1'b1 && int'(num4) == want) && t < 40) begin
            tick();
            t++;
        end
        chk("wait_strobe4_in_budget", int'(t < 40), 1);
    endtask

    int tbl4_num[10] = '{0, 0, 0, 1, 1, 2, 2, 3, 3, 0};
    int mw_left, dones, exp_n;

    initial begin
        repeat (2) @(posedge clk);
        tick();
        reset = 1'b0;
        chk_on = 1;
        chk("reset_lc4", int'(lc4), 0);
        chk("reset_bz8", int'(bz8), 0);
        chk("reset_num4", int'(num4), 0);

        // Ascending run with modwait low; literal timing for all three sizes.
        new_set = 1'b1;
        tick();
        new_set = 1'b0;
        for (int i = 1; i <= 31; i++) begin
            if (i > 1) tick();
            if (i <= 9) begin
                chk($sformatf("t1_lc4_c%0d", i), int'(lc4), int'(i <= 7 && i % 2 == 1));
                chk($sformatf("t1_num4_c%0d", i), int'(num4), tbl4_num[i]);
                chk($sformatf("t1_done4_c%0d", i), int'(dn4), int'(i == 8));
                chk($sformatf("t1_busy4_c%0d", i), int'(bz4), int'(i <= 8));
                chk($sformatf("t1_model4_lc_c%0d", i), int'(m_strb[0]), int'(i <= 7 && i % 2 == 1));
            end
            if (i <= 3) begin
                chk($sformatf("t1_lc1_c%0d", i), int'(lc1), int'(i == 1));
                chk($sformatf("t1_done1_c%0d", i), int'(dn1), int'(i == 2));
                chk($sformatf("t1_busy1_c%0d", i), int'(bz1), int'(i <= 2));
            end
            exp_n = (i <= 30) ? (((i - 1) / 4 > 7) ? 7 : (i - 1) / 4) : 0;
            chk($sformatf("t1_lc8_c%0d", i), int'(lc8), int'(i <= 29 && (i - 1) % 4 == 0));
            chk($sformatf("t1_num8_c%0d", i), int'(num8), exp_n);
            chk($sformatf("t1_done8_c%0d", i), int'(dn8), int'(i == 30));
            chk($sformatf("t1_model8_done_c%0d", i), int'(m_done[1]), int'(i == 30));
        end

        // Descending run, modwait high for 3 cycles after every strobe;
        // reverse flips mid-sequence and must be ignored.
        clear_log();
        reverse = 1'b1;
        new_set = 1'b1;
        tick();
        new_set = 1'b0;
        mw_left = 0;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            if (i == 5) reverse = 1'b0;
            if (lc4 === 1'b1) mw_left = 3;
            if (dn4 === 1'b1) dones++;
            modwait = (mw_left > 0);
            if (mw_left > 0) mw_left--;
            tick();
        end
        modwait = 1'b0;
        tick();
        chk("t2_strobes", q_snum.size(), 4);
        for (int i = 0; i < 4 && i < q_snum.size(); i++)
            chk($sformatf("t2_idx%0d", i), q_snum[i], 3 - i);
        for (int i = 1; i < q_scyc.size(); i++)
            chk($sformatf("t2_gap%0d", i), q_scyc[i] - q_scyc[i - 1], 4);
        chk("t2_dones", dones, 1);

        // Request queued during the WAIT after index 1.
        clear_log();
        new_set = 1'b1;
        tick();
        new_set = 1'b0;
        wait_strobe4(1);
        tick();
        new_set = 1'b1;
        tick();
        new_set = 1'b0;
        repeat (30) tick();
        chk("t4_strobes", q_snum.size(), 8);
        chk("t4_dones", q_dcyc.size(), 2);
        if (q_snum.size() >= 5 && q_dcyc.size() >= 1) begin
            chk("t4_restart_idx", q_snum[4], 0);
            chk("t4_restart_lat", q_scyc[4] - q_dcyc[0], 2);
        end else begin
            chk("t4_restart_seen", 0, 1);
        end

        // Abort in WAIT after index 1 with a request pending.
        clear_log();
        new_set = 1'b1;
        tick();
        new_set = 1'b0;
        wait_strobe4(1);
        new_set = 1'b1;
        tick();
        new_set = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t5_busy_after_abort", int'(bz4), 0);
        repeat (15) tick();
        chk("t5_strobes", q_snum.size(), 2);
        chk("t5_dones", q_dcyc.size(), 0);
        chk("t5_busy_end", int'(bz4), 0);

        // Reset during SETTLE of the 8-entry instance, then a fresh start.
        clear_log();
        new_set = 1'b1;
        tick();
        new_set = 1'b0;
        tick();
        chk("t6_in_settle", int'(bz8 && !lc8), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_lc8", int'(lc8), 0);
        chk("t6_num8", int'(num8), 0);
        chk("t6_busy8", int'(bz8), 0);
        chk("t6_done8", int'(dn8), 0);
        new_set = 1'b1;
        tick();
        new_set = 1'b0;
        chk("t6_restart_lc8", int'(lc8), 1);
        chk("t6_restart_num8", int'(num8), 0);
        chk("t6_n1_lc", int'(lc1), 1);
        tick();
        chk("t6_n1_done", int'(dn1), 1);
        chk("t6_n1_no_lc", int'(lc1), 0);
        repeat (40) tick();

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            new_set = ($urandom_range(0, 7) == 0);
            modwait = ($urandom_range(0, 2) == 0);
            reverse = 1'($urandom_range(0, 1));
            abort   = ($urandom_range(0, 39) == 0);
            reset   = ($urandom_range(0, 299) == 0);
            tick();
        end
        reset = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
